// File: rtl/stump_alu_checker_if.sv
// rtl/stump_alu_checker_if.sv - ALU stimulus/response bus and checker status bundle
interface stump_alu_checker_if;
    logic        start;
    logic        sample;
    logic [15:0] operand_A;
    logic [15:0] operand_B;
    logic [2:0]  func;
    logic        c_in;
    logic        csh;
    logic [15:0] result;
    logic [3:0]  flags_out;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] test_count;
    logic [15:0] error_count;
    logic [15:0] fail_index;
    logic [15:0] fail_exp_result;
    logic [3:0]  fail_exp_flags;

    modport master (
        output start, sample, operand_A, operand_B, func, c_in, csh, result, flags_out,
        input  busy, done, pass, test_count, error_count, fail_index,
               fail_exp_result, fail_exp_flags
    );

    modport slave (
        input  start, sample, operand_A, operand_B, func, c_in, csh, result, flags_out,
        output busy, done, pass, test_count, error_count, fail_index,
               fail_exp_result, fail_exp_flags
    );
endinterface

// File: rtl/stump_alu_checker.sv
// rtl/stump_alu_checker.sv - Stump ALU response checker with golden model and first-fail capture
module stump_alu_checker #(
    parameter int N_TESTS = 108
) (
    input logic               clk,
    input logic               rst,
    stump_alu_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [15:0] N_LAST = 16'(N_TESTS);

    state_t      state_q, state_d;
    logic        s1_valid_q, s1_valid_d;
    logic [15:0] s1_a_q, s1_a_d;
    logic [15:0] s1_b_q, s1_b_d;
    logic [2:0]  s1_func_q, s1_func_d;
    logic        s1_cin_q, s1_cin_d;
    logic        s1_csh_q, s1_csh_d;
    logic [15:0] s1_res_q, s1_res_d;
    logic [3:0]  s1_flags_q, s1_flags_d;
    logic [15:0] test_count_q, test_count_d;
    logic [15:0] error_count_q, error_count_d;
    logic [15:0] fail_index_q, fail_index_d;
    logic [15:0] fail_res_q, fail_res_d;
    logic [3:0]  fail_flags_q, fail_flags_d;
    logic        first_fail_q, first_fail_d;

    logic [15:0] beff;
    logic        cin_eff;
    logic        is_sub;
    logic        is_logic;
    logic [16:0] sum;
    logic [15:0] exp_result;
    logic [3:0]  exp_flags;
    logic        v_bit;
    logic        c_bit;
    logic        mismatch;
    logic        check;

    // Golden model operates on the stage-1 registered operands.
    always_comb begin
        beff     = s1_b_q;
        cin_eff  = 1'b0;
        is_sub   = 1'b0;
        is_logic = 1'b0;
        case (s1_func_q)
            3'd1: cin_eff = s1_cin_q;
            3'd2: begin beff = ~s1_b_q; cin_eff = 1'b1;      is_sub = 1'b1; end
            3'd3: begin beff = ~s1_b_q; cin_eff = ~s1_cin_q; is_sub = 1'b1; end
            3'd4, 3'd5: is_logic = 1'b1;
            default: ;
        endcase
        sum = {1'b0, s1_a_q} + {1'b0, beff} + {16'd0, cin_eff};
        if (is_logic) begin
            exp_result = (s1_func_q == 3'd4) ? (s1_a_q & s1_b_q) : (s1_a_q | s1_b_q);
            v_bit      = 1'b0;
            c_bit      = s1_csh_q;
        end else begin
            exp_result = sum[15:0];
            v_bit      = (s1_a_q[15] == beff[15]) && (sum[15] != s1_a_q[15]);
            c_bit      = is_sub ? ~sum[16] : sum[16];
        end
        exp_flags = {exp_result[15], exp_result == 16'd0, v_bit, c_bit};
        mismatch  = (s1_res_q != exp_result) || (s1_flags_q != exp_flags);
    end

    always_comb begin
        state_d       = state_q;
        s1_valid_d    = bus.sample && (state_q == RUN) && !bus.start;
        s1_a_d        = s1_a_q;
        s1_b_d        = s1_b_q;
        s1_func_d     = s1_func_q;
        s1_cin_d      = s1_cin_q;
        s1_csh_d      = s1_csh_q;
        s1_res_d      = s1_res_q;
        s1_flags_d    = s1_flags_q;
        test_count_d  = test_count_q;
        error_count_d = error_count_q;
        fail_index_d  = fail_index_q;
        fail_res_d    = fail_res_q;
        fail_flags_d  = fail_flags_q;
        first_fail_d  = first_fail_q;
        check         = s1_valid_q && (state_q == RUN);

        if (bus.sample) begin
            s1_a_d     = bus.operand_A;
            s1_b_d     = bus.operand_B;
            s1_func_d  = bus.func;
            s1_cin_d   = bus.c_in;
            s1_csh_d   = bus.csh;
            s1_res_d   = bus.result;
            s1_flags_d = bus.flags_out;
        end

        // start wins over a sample landing in stage 2 in the same cycle.
        if (bus.start) begin
            state_d       = RUN;
            test_count_d  = 16'd0;
            error_count_d = 16'd0;
            fail_index_d  = 16'd0;
            fail_res_d    = 16'd0;
            fail_flags_d  = 4'd0;
            first_fail_d  = 1'b0;
        end else if (check) begin
            test_count_d = test_count_q + 16'd1;
            if (mismatch) begin
                if (error_count_q != 16'hFFFF) error_count_d = error_count_q + 16'd1;
                if (!first_fail_q) begin
                    first_fail_d = 1'b1;
                    fail_index_d = test_count_q;
                    fail_res_d   = exp_result;
                    fail_flags_d = exp_flags;
                end
            end
            if (test_count_d == N_LAST) state_d = DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            s1_valid_q    <= 1'b0;
            s1_a_q        <= 16'd0;
            s1_b_q        <= 16'd0;
            s1_func_q     <= 3'd0;
            s1_cin_q      <= 1'b0;
            s1_csh_q      <= 1'b0;
            s1_res_q      <= 16'd0;
            s1_flags_q    <= 4'd0;
            test_count_q  <= 16'd0;
            error_count_q <= 16'd0;
            fail_index_q  <= 16'd0;
            fail_res_q    <= 16'd0;
            fail_flags_q  <= 4'd0;
            first_fail_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            s1_valid_q    <= s1_valid_d;
            s1_a_q        <= s1_a_d;
            s1_b_q        <= s1_b_d;
            s1_func_q     <= s1_func_d;
            s1_cin_q      <= s1_cin_d;
            s1_csh_q      <= s1_csh_d;
            s1_res_q      <= s1_res_d;
            s1_flags_q    <= s1_flags_d;
            test_count_q  <= test_count_d;
            error_count_q <= error_count_d;
            fail_index_q  <= fail_index_d;
            fail_res_q    <= fail_res_d;
            fail_flags_q  <= fail_flags_d;
            first_fail_q  <= first_fail_d;
        end
    end

    assign bus.busy            = (state_q == RUN);
    assign bus.done            = (state_q == DONE);
    assign bus.pass            = (state_q == DONE) && (error_count_q == 16'd0);
    assign bus.test_count      = test_count_q;
    assign bus.error_count     = error_count_q;
    assign bus.fail_index      = fail_index_q;
    assign bus.fail_exp_result = fail_res_q;
    assign bus.fail_exp_flags  = fail_flags_q;
endmodule

// File: tb/tb_stump_alu_checker.sv
// tb/tb_stump_alu_checker.sv - scoreboard bench for stump_alu_checker
module tb_stump_alu_checker;
    typedef struct {
        int          due;
        logic [15:0] tc;
        logic [15:0] ec;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;
    exp_t q[$];
    exp_t mon_e;
    logic [15:0] exp_tc;
    logic [15:0] exp_ec;
    logic [15:0] pa [9];
    logic [15:0] pb [9];

    stump_alu_checker_if bus ();

    stump_alu_checker #(.N_TESTS(108)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference built on integer arithmetic rather than adder bit tricks.
    function automatic logic [19:0] alu_ref(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                                            input logic ci, input logic cs);
        int ia, ib, sa, sb, ir, sr, k;
        logic [15:0] r;
        logic v, c;
        ia = int'(a);
        ib = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        k  = 0;
        r  = 16'd0;
        v  = 1'b0;
        c  = 1'b0;
        case (f)
            3'd4: begin r = a & b; c = cs; end
            3'd5: begin r = a | b; c = cs; end
            3'd2, 3'd3: begin
                if (f == 3'd3 && ci) k = 1;
                ir = ia - ib - k;
                sr = sa - sb - k;
                r  = ir[15:0];
                c  = (ir < 0);
                v  = (sr > 32767) || (sr < -32768);
            end
            default: begin
                if (f == 3'd1 && ci) k = 1;
                ir = ia + ib + k;
                sr = sa + sb + k;
                r  = ir[15:0];
                c  = (ir > 65535);
                v  = (sr > 32767) || (sr < -32768);
            end
        endcase
        return {r, r[15], (r == 16'd0), v, c};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic drive(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic cs, input logic [15:0] r, input logic [3:0] fl,
                         input bit push, input bit corrupt);
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.sample    = 1'b1;
        bus.func      = f;
        bus.operand_A = a;
        bus.operand_B = b;
        bus.c_in      = ci;
        bus.csh       = cs;
        bus.result    = r;
        bus.flags_out = fl;
        if (push) begin
            exp_tc = exp_tc + 16'd1;
            if (corrupt) exp_ec = exp_ec + 16'd1;
            q.push_back('{due: cyc + 2, tc: exp_tc, ec: exp_ec});
        end
    endtask

    task automatic good(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic cs, input bit push);
        logic [19:0] e;
        e = alu_ref(f, a, b, ci, cs);
        drive(f, a, b, ci, cs, e[19:4], e[3:0], push, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.sample = 1'b0;
            bus.start  = 1'b0;
        end
    endtask

    task automatic do_start();
        @(posedge clk);
        #1;
        bus.sample = 1'b0;
        bus.start  = 1'b1;
        exp_tc     = 16'd0;
        exp_ec     = 16'd0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic run_all(input bit push);
        for (int i = 0; i < 108; i++)
            good(3'((i / 9) % 6), pa[i % 9], pb[i % 9], (i >= 54), (i >= 54), push);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        exp_tc = 16'd0;
        exp_ec = 16'd0;
        pa = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h5000, 16'h4000, 16'hC000, 16'h1234};
        pb = '{16'h0000, 16'h0001, 16'h0001, 16'h8000, 16'h0001, 16'h5000, 16'h3FFF, 16'hBFFF, 16'h5678};
        rst = 1'b1;
        bus.start = 1'b0;
        bus.sample = 1'b0;
        bus.func = 3'd0;
        bus.operand_A = 16'd0;
        bus.operand_B = 16'd0;
        bus.c_in = 1'b0;
        bus.csh = 1'b0;
        bus.result = 16'd0;
        bus.flags_out = 4'd0;

        fork
            forever begin
                @(negedge clk);
                if (q.size() > 0 && q[0].due <= cyc) begin
                    mon_e = q.pop_front();
                    if (mon_e.due < cyc) begin
                        total++;
                        bad++;
                        $display("FAIL sb_late: due cycle %0d passed at cycle %0d", mon_e.due, cyc);
                    end else begin
                        chk("sb_test_count", 32'(bus.test_count), 32'(mon_e.tc));
                        chk("sb_error_count", 32'(bus.error_count), 32'(mon_e.ec));
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_pass", 32'(bus.pass), 0);
        chk("rst_test_count", 32'(bus.test_count), 0);
        chk("rst_error_count", 32'(bus.error_count), 0);
        chk("rst_fail_index", 32'(bus.fail_index), 0);
        rst = 1'b0;

        good(3'd0, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);
        good(3'd2, 16'h0005, 16'h0003, 1'b0, 1'b0, 1'b0);
        idle(3);
        chk("idle_sample_ignored", 32'(bus.test_count), 0);
        chk("idle_busy", 32'(bus.busy), 0);

        do_start();
        chk("run_busy", 32'(bus.busy), 1);
        run_all(1'b1);
        idle(3);
        chk("full_done", 32'(bus.done), 1);
        chk("full_pass", 32'(bus.pass), 1);
        chk("full_test_count", 32'(bus.test_count), 108);
        chk("full_error_count", 32'(bus.error_count), 0);
        chk("full_busy", 32'(bus.busy), 0);
        good(3'd0, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
        good(3'd1, 16'h0002, 16'h0001, 1'b1, 1'b0, 1'b0);
        idle(3);
        chk("done_sample_ignored", 32'(bus.test_count), 108);

        do_start();
        chk("restart_test_count", 32'(bus.test_count), 0);
        chk("restart_done", 32'(bus.done), 0);
        drive(3'd2, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 4'h4, 1'b1, 1'b0);
        drive(3'd0, 16'h4000, 16'h3FFF, 1'b1, 1'b0, 16'h7FFF, 4'h0, 1'b1, 1'b0);
        drive(3'd0, 16'h5000, 16'h5000, 1'b0, 1'b0, 16'hA000, 4'hA, 1'b1, 1'b0);
        drive(3'd4, 16'hC000, 16'hBFFF, 1'b0, 1'b1, 16'h8000, 4'h9, 1'b1, 1'b0);
        drive(3'd5, 16'hC000, 16'hBFFF, 1'b0, 1'b0, 16'hFFFF, 4'h8, 1'b1, 1'b0);
        drive(3'd0, 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 4'h1, 1'b1, 1'b1);
        idle(3);
        chk("first_fail_index", 32'(bus.fail_index), 5);
        chk("first_fail_result", 32'(bus.fail_exp_result), 32'h0002);
        chk("first_fail_flags", 32'(bus.fail_exp_flags), 0);
        for (int i = 0; i < 102; i++) begin
            logic [19:0] e;
            e = alu_ref(3'((i / 9) % 6), pa[i % 9], pb[i % 9], (i >= 54), (i >= 54));
            if (i == 20)
                drive(3'((i / 9) % 6), pa[i % 9], pb[i % 9], (i >= 54), (i >= 54),
                      e[19:4] ^ 16'h0001, e[3:0], 1'b1, 1'b1);
            else
                drive(3'((i / 9) % 6), pa[i % 9], pb[i % 9], (i >= 54), (i >= 54),
                      e[19:4], e[3:0], 1'b1, 1'b0);
        end
        idle(3);
        chk("err_done", 32'(bus.done), 1);
        chk("err_pass", 32'(bus.pass), 0);
        chk("err_test_count", 32'(bus.test_count), 108);
        chk("err_error_count", 32'(bus.error_count), 2);
        chk("err_fail_index_kept", 32'(bus.fail_index), 5);

        do_start();
        for (int i = 0; i < 10; i++) good(3'(i % 6), pa[i % 9], pb[i % 9], 1'b0, 1'b1, 1'b1);
        idle(3);
        do_start();
        chk("midrun_start_count", 32'(bus.test_count), 0);
        chk("midrun_start_errors", 32'(bus.error_count), 0);
        chk("midrun_start_busy", 32'(bus.busy), 1);
        @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.sample = 1'b1;
        idle(3);
        chk("start_with_sample_dropped", 32'(bus.test_count), 0);

        for (int i = 0; i < 4; i++) good(3'd1, pa[i], pb[i], 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.sample = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_test_count", 32'(bus.test_count), 0);
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_done", 32'(bus.done), 0);
        rst = 1'b0;
        idle(3);
        chk("midrst_pipeline_flushed", 32'(bus.test_count), 0);

        do_start();
        run_all(1'b1);
        idle(3);
        chk("rerun_done", 32'(bus.done), 1);
        chk("rerun_pass", 32'(bus.pass), 1);
        chk("rerun_test_count", 32'(bus.test_count), 108);
        chk("sb_drained", 32'(q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
